// File: rtl/hostif_mbx_slave.sv
// rtl/hostif_mbx_slave.sv - Avalon-MM host register slave with event interrupts and fabric-to-host mailbox
module hostif_mbx_slave #(
    parameter int          MBX_DEPTH = 8,
    parameter logic [31:0] ID_VALUE  = 32'h504C4D42
) (
    input  logic        clk100_clk,
    input  logic        reset_clk100_reset_n,
    input  logic [17:0] s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_writedata,
    input  logic [3:0]  s0_byteenable,
    input  logic        s0_burstcount,
    input  logic        s0_debugaccess,
    output logic [31:0] s0_readdata,
    output logic        s0_readdatavalid,
    output logic        s0_waitrequest,
    input  logic        mbx_valid,
    input  logic [31:0] mbx_data,
    output logic        mbx_full,
    input  logic [3:0]  evt_i,
    output logic        irq_o
);

    localparam int AW = $clog2(MBX_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [MBX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    evt_q, pend;
    logic [4:0]    irq_en;
    logic [31:0]   scratch;
    logic          ovf, udf;

    logic          sel_ok, wr_en, rd_mbx, mbx_empty, push, pop;
    logic [2:0]    idx;
    logic [31:0]   rdata;
    logic [3:0]    pend_clr;
    logic [1:0]    stat_clr;
    logic          unused_ok;

    assign unused_ok      = ^{s0_burstcount, s0_debugaccess, s0_address[1:0]};
    assign s0_waitrequest = 1'b0;

    assign sel_ok    = (s0_address[17:5] == 13'd0);
    assign idx       = s0_address[4:2];
    // A simultaneous read wins, so the write is suppressed entirely.
    assign wr_en     = s0_write & ~s0_read & sel_ok;
    assign rd_mbx    = s0_read & sel_ok & (idx == 3'd3);
    assign mbx_full  = (count == CW'(MBX_DEPTH));
    assign mbx_empty = (count == '0);
    // Full is judged before any same-cycle pop, so a push into a full mailbox is dropped.
    assign push      = mbx_valid & ~mbx_full;
    assign pop       = rd_mbx & ~mbx_empty;

    always_comb begin
        pend_clr = 4'd0;
        stat_clr = 2'd0;
        if (wr_en && idx == 3'd1) pend_clr = s0_writedata[3:0];
        if (wr_en && idx == 3'd4) stat_clr = s0_writedata[9:8];
    end

    always_comb begin
        rdata = 32'd0;
        if (sel_ok) begin
            case (idx)
                3'd0:    rdata = ID_VALUE;
                3'd1:    rdata = {27'd0, ~mbx_empty, pend};
                3'd2:    rdata = {27'd0, irq_en};
                3'd3:    rdata = mbx_empty ? 32'd0 : mem[rd_ptr];
                3'd4:    rdata = {22'd0, udf, ovf, 3'd0, 5'(count)};
                3'd5:    rdata = scratch;
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk100_clk) begin
        if (push) mem[wr_ptr] <= mbx_data;
    end

    always_ff @(posedge clk100_clk) begin
        if (!reset_clk100_reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            evt_q            <= 4'd0;
            pend             <= 4'd0;
            irq_en           <= 5'd0;
            scratch          <= 32'd0;
            ovf              <= 1'b0;
            udf              <= 1'b0;
            irq_o            <= 1'b0;
            s0_readdata      <= 32'd0;
            s0_readdatavalid <= 1'b0;
        end else begin
            s0_readdatavalid <= s0_read;
            s0_readdata      <= s0_read ? rdata : 32'd0;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);

            evt_q <= evt_i;
            pend  <= (pend & ~pend_clr) | (evt_i & ~evt_q);
            ovf   <= (ovf & ~stat_clr[0]) | (mbx_valid & mbx_full);
            udf   <= (udf & ~stat_clr[1]) | (rd_mbx & mbx_empty);
            irq_o <= |({~mbx_empty, pend} & irq_en);

            if (wr_en && idx == 3'd2) irq_en <= s0_writedata[4:0];
            if (wr_en && idx == 3'd5) begin
                for (int b = 0; b < 4; b++) begin
                    if (s0_byteenable[b]) scratch[8*b +: 8] <= s0_writedata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_hostif_mbx_slave.sv
// tb/tb_hostif_mbx_slave.sv - scoreboard bench for hostif_mbx_slave
module tb_hostif_mbx_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [17:0] s0_address;
    logic        s0_read, s0_write;
    logic [31:0] s0_writedata;
    logic [3:0]  s0_byteenable;
    logic [31:0] s0_readdata;
    logic        s0_readdatavalid, s0_waitrequest;
    logic        mbx_valid;
    logic [31:0] mbx_data;
    logic        mbx_full;
    logic [3:0]  evt_i;
    logic        irq_o;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    hostif_mbx_slave dut (
        .clk100_clk           (clk),
        .reset_clk100_reset_n (resetn),
        .s0_address           (s0_address),
        .s0_read              (s0_read),
        .s0_write             (s0_write),
        .s0_writedata         (s0_writedata),
        .s0_byteenable        (s0_byteenable),
        .s0_burstcount        (1'b1),
        .s0_debugaccess       (1'b0),
        .s0_readdata          (s0_readdata),
        .s0_readdatavalid     (s0_readdatavalid),
        .s0_waitrequest       (s0_waitrequest),
        .mbx_valid            (mbx_valid),
        .mbx_data             (mbx_data),
        .mbx_full             (mbx_full),
        .evt_i                (evt_i),
        .irq_o                (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (s0_readdatavalid) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_rdv: readdatavalid high with data %08h, none required", s0_readdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (s0_readdata === e.data && cyc == e.cyc) n_pass++;
                else $display("FAIL %s: got %08h at cycle %0d, required %08h at cycle %0d",
                              e.name, s0_readdata, cyc, e.data, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, required %08h", name, act, exp);
    endtask

    task automatic do_read(input logic [17:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.data = exp;
        e.cyc  = cyc + 1;
        e.name = name;
        exp_q.push_back(e);
        s0_address = addr;
        s0_read    = 1'b1;
        tick();
        s0_read    = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] addr, input logic [31:0] data, input logic [3:0] be);
        s0_address    = addr;
        s0_writedata  = data;
        s0_byteenable = be;
        s0_write      = 1'b1;
        tick();
        s0_write      = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] data);
        mbx_valid = 1'b1;
        mbx_data  = data;
        tick();
        mbx_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        s0_address = '0; s0_read = 0; s0_write = 0; s0_writedata = '0; s0_byteenable = 4'hF;
        mbx_valid = 0; mbx_data = '0; evt_i = 4'd0;
        #1;
        repeat (3) tick();
        check("wait_in_reset", {31'd0, s0_waitrequest}, 32'd0);
        check("rdv_in_reset", {31'd0, s0_readdatavalid}, 32'd0);
        check("irq_in_reset", {31'd0, irq_o}, 32'd0);
        check("full_in_reset", {31'd0, mbx_full}, 32'd0);
        resetn = 1'b1;
        tick();

        do_read(18'h00, 32'h504C4D42, "id");
        do_read(18'h08, 32'h0, "irq_en_rst");
        do_read(18'h18, 32'h0, "reserved_18");

        do_push(32'h11); do_push(32'h22); do_push(32'h33);
        do_read(18'h10, 32'h3, "stat_cnt3");
        do_read(18'h04, 32'h10, "pend_nonempty");
        do_read(18'h0C, 32'h11, "pop0");
        do_read(18'h0C, 32'h22, "pop1");
        do_read(18'h0C, 32'h33, "pop2");
        do_read(18'h0C, 32'h0, "pop_empty");
        do_read(18'h10, 32'h200, "stat_udf");
        do_write(18'h10, 32'h200, 4'hF);
        do_read(18'h10, 32'h0, "stat_udf_clr");

        for (int i = 0; i < 9; i++) begin
            do_push(32'hA0 + i);
            if (i == 6) check("full_after7", {31'd0, mbx_full}, 32'd0);
            if (i == 7) check("full_after8", {31'd0, mbx_full}, 32'd1);
        end
        do_read(18'h10, 32'h108, "stat_ovf");
        do_write(18'h10, 32'h100, 4'h0);
        do_read(18'h10, 32'h008, "stat_ovf_clr");
        mbx_valid = 1'b1; mbx_data = 32'hEE;
        do_read(18'h0C, 32'hA0, "pop_full_push");
        mbx_valid = 1'b0;
        do_read(18'h10, 32'h107, "stat_full_pushpop");
        for (int i = 1; i < 8; i++) do_read(18'h0C, 32'hA0 + i, "drain");
        do_write(18'h10, 32'h100, 4'hF);
        do_read(18'h10, 32'h0, "stat_drained");

        mbx_valid = 1'b1; mbx_data = 32'h55;
        do_read(18'h0C, 32'h0, "pop_empty_push");
        mbx_valid = 1'b0;
        do_read(18'h10, 32'h201, "stat_empty_pushpop");
        do_read(18'h0C, 32'h55, "pop_landed");
        do_write(18'h10, 32'h200, 4'hF);

        do_write(18'h08, 32'hFFFFFFFF, 4'h1);
        do_read(18'h08, 32'h1F, "irq_en_mask");
        do_write(18'h08, 32'h02, 4'hF);
        evt_i = 4'h2; tick();
        evt_i = 4'h0; tick();
        check("irq_evt1", {31'd0, irq_o}, 32'd1);
        do_read(18'h04, 32'h02, "pend_evt1");
        evt_i = 4'h2;
        do_write(18'h04, 32'h02, 4'hF);
        evt_i = 4'h0;
        do_read(18'h04, 32'h02, "pend_set_wins");
        do_write(18'h04, 32'h02, 4'hF);
        do_read(18'h04, 32'h0, "pend_cleared");
        check("irq_cleared", {31'd0, irq_o}, 32'd0);

        do_write(18'h14, 32'hFFFFFFFF, 4'hF);
        do_write(18'h14, 32'h12345678, 4'h5);
        do_read(18'h14, 32'hFF34FF78, "scratch_be");
        do_write(18'h20, 32'hDEADBEEF, 4'hF);
        do_read(18'h20, 32'h0, "out_of_range");
        do_write(18'h34, 32'h0, 4'hF);
        s0_write = 1'b1; s0_writedata = 32'h0;
        do_read(18'h14, 32'hFF34FF78, "rd_wr_same");
        s0_write = 1'b0;
        do_read(18'h14, 32'hFF34FF78, "scratch_kept");

        do_write(18'h08, 32'h10, 4'hF);
        do_push(32'h77); do_push(32'h88);
        tick();
        check("irq_mbx", {31'd0, irq_o}, 32'd1);
        resetn = 1'b0;
        s0_address = 18'h0C;
        s0_read = 1'b1;
        tick();
        s0_read = 1'b0;
        check("wait_mid_reset", {31'd0, s0_waitrequest}, 32'd0);
        check("rdv_discarded", {31'd0, s0_readdatavalid}, 32'd0);
        resetn = 1'b1;
        tick();
        check("irq_after_reset", {31'd0, irq_o}, 32'd0);
        check("full_after_reset", {31'd0, mbx_full}, 32'd0);
        do_read(18'h10, 32'h0, "stat_after_reset");
        do_read(18'h14, 32'h0, "scratch_after_reset");
        do_read(18'h00, 32'h504C4D42, "id_after_reset");

        repeat (3) tick();
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_rdv: %0d responses outstanding, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
